// File: rtl/alu_pkg.sv
// Shared ALU definitions used by the ALU result FIFO.
//   alu_result_t       : one ALU result, {cout, z}
//   ALU_W              : ALU data width
//   ALU_RES_FIFO_DEPTH : default result FIFO depth
//   result_parity()    : even parity over a result, used when the FIFO is
//                        built with ALU_RESULT_FIFO_PARITY_EN
package alu_pkg;

    localparam int ALU_W              = 8;
    localparam int ALU_RES_FIFO_DEPTH = 4;

    typedef struct packed {
        logic             cout;
        logic [ALU_W-1:0] z;
    } alu_result_t;

    function automatic logic result_parity(input alu_result_t r);
        return ^r;
    endfunction

endpackage

// File: rtl/alu_result_fifo_if.sv
// Push/stop handshake bundle for alu_result_fifo.
//   Input side : pushin, z_in, cout_in (to FIFO), stopout (from FIFO)
//   Output side: pushout, z_out, cout_out, count (from FIFO), stopin (to FIFO)
//   par_out exists only when ALU_RESULT_FIFO_PARITY_EN is defined.
// Modports: slave = the FIFO, master = the surrounding ALU/consumer logic.
interface alu_result_fifo_if import alu_pkg::*; #(
    parameter int DEPTH = ALU_RES_FIFO_DEPTH
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             pushin;
    logic             stopout;
    logic [ALU_W-1:0] z_in;
    logic             cout_in;
    logic             pushout;
    logic             stopin;
    logic [ALU_W-1:0] z_out;
    logic             cout_out;
    logic [CNT_W-1:0] count;
`ifdef ALU_RESULT_FIFO_PARITY_EN
    logic             par_out;

    modport slave (
        input  pushin, z_in, cout_in, stopin,
        output stopout, pushout, z_out, cout_out, count, par_out
    );
    modport master (
        output pushin, z_in, cout_in, stopin,
        input  stopout, pushout, z_out, cout_out, count, par_out
    );
`else
    modport slave (
        input  pushin, z_in, cout_in, stopin,
        output stopout, pushout, z_out, cout_out, count
    );
    modport master (
        output pushin, z_in, cout_in, stopin,
        input  stopout, pushout, z_out, cout_out, count
    );
`endif

endinterface

// File: rtl/alu_fifo_mem.sv
// Result storage for alu_result_fifo: DEPTH x WIDTH register array,
// one synchronous write port, one asynchronous (show-ahead) read port.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational from raddr)
// Contents are intentionally not reset.
module alu_fifo_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: buffers ALU results {cout, z} between the ALU and its
// consumer using the push/stop handshake on both sides.
//   clk : rising-edge clock
//   rst : asynchronous, active-low reset (clears pointers and count)
//   bus : alu_result_fifo_if.slave
//         pushin/z_in/cout_in in, stopout out (upstream side)
//         pushout/z_out/cout_out/count out, stopin in (downstream side)
// Optional build macro ALU_RESULT_FIFO_PARITY_EN adds a stored even-parity
// bit per entry and the par_out port on the interface.
// Flags are decoded from the registered count only, so stopout/pushout
// never depend combinationally on pushin/stopin.
module alu_result_fifo import alu_pkg::*; #(
    parameter int DEPTH = ALU_RES_FIFO_DEPTH,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input logic              clk,
    input logic              rst,
    alu_result_fifo_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
`ifdef ALU_RESULT_FIFO_PARITY_EN
    localparam int ENTRY_W = ALU_W + 2;
`else
    localparam int ENTRY_W = ALU_W + 1;
`endif
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [CNT_W-1:0]   count_q;
    logic               full;
    logic               empty;
    logic               wr_en;
    logic               rd_en;
    alu_result_t        in_res;
    alu_result_t        head_res;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    // A full FIFO refuses writes even when a read frees a slot this edge.
    assign wr_en = bus.pushin && !full;
    assign rd_en = !empty && !bus.stopin;

    assign in_res = '{cout: bus.cout_in, z: bus.z_in};
`ifdef ALU_RESULT_FIFO_PARITY_EN
    assign wr_entry = {result_parity(in_res), in_res};
`else
    assign wr_entry = in_res;
`endif

    alu_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (rd_entry)
    );

    assign head_res = rd_entry[ALU_W:0];

    // Pointers are AW bits wide; DEPTH is a power of two so they wrap freely.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Head data is masked to zero while empty (storage is never cleared).
    assign bus.pushout  = !empty;
    assign bus.stopout  = full;
    assign bus.z_out    = empty ? '0 : head_res.z;
    assign bus.cout_out = !empty && head_res.cout;
    assign bus.count    = count_q;
`ifdef ALU_RESULT_FIFO_PARITY_EN
    assign bus.par_out  = !empty && rd_entry[ENTRY_W-1];
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// Testbench for alu_result_fifo (DEPTH = 4): directed vectors, a queue
// model of the FIFO, per-cycle comparison of all outputs, and literal
// expectations for each directed scenario.
module tb_alu_result_fifo;
    import alu_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    alu_result_fifo_if #(.DEPTH(DEPTH)) bus ();

    alu_result_fifo #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: queue of {cout, z}, updated by the handshake rules.
    logic [8:0] mq[$];
    logic [7:0] out_log[$];

    always @(negedge rst) mq.delete();

    always @(posedge clk) begin
        if (rst) begin
            bit do_wr, do_rd;
            do_wr = bus.pushin && (mq.size() < DEPTH);
            do_rd = (mq.size() != 0) && !bus.stopin;
            if (do_rd) begin
                out_log.push_back(bus.z_out);
                void'(mq.pop_front());
            end
            if (do_wr) mq.push_back({bus.cout_in, bus.z_in});
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst) begin
            logic [8:0] h;
            h = (mq.size() != 0) ? mq[0] : 9'h0;
            chk("pushout",  bus.pushout,  mq.size() != 0);
            chk("stopout",  bus.stopout,  mq.size() == DEPTH);
            chk("count",    bus.count,    mq.size());
            chk("z_out",    bus.z_out,    h[7:0]);
            chk("cout_out", bus.cout_out, h[8]);
`ifdef ALU_RESULT_FIFO_PARITY_EN
            chk("par_out",  bus.par_out,  ^h);
`endif
        end
    end

    // Offer one value and hold it until the FIFO accepts it.
    task automatic push(input logic [7:0] z, input logic c);
        bit acc;
        acc = 1'b0;
        bus.pushin  = 1'b1;
        bus.z_in    = z;
        bus.cout_in = c;
        for (int i = 0; i < 50 && !acc; i++) begin
            acc = !bus.stopout;
            @(negedge clk);
        end
        if (!acc) chk("push_timeout", 32'd0, 32'd1);
        bus.pushin = 1'b0;
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 50 && bus.pushout; i++) @(negedge clk);
        chk("drain_timeout", bus.pushout, 1'b0);
    endtask

    task automatic chk_log(input string name, input logic [7:0] exp[$]);
        chk({name, "_len"}, out_log.size(), exp.size());
        for (int i = 0; i < exp.size() && i < out_log.size(); i++)
            chk(name, out_log[i], exp[i]);
        out_log.delete();
    endtask

    initial begin
        bus.pushin  = 1'b0;
        bus.z_in    = '0;
        bus.cout_in = 1'b0;
        bus.stopin  = 1'b0;

        // Reset then single result
        repeat (3) @(negedge clk);
        chk("rst_pushout", bus.pushout, 1'b0);
        chk("rst_stopout", bus.stopout, 1'b0);
        chk("rst_count",   bus.count,   0);
        chk("rst_z_out",   bus.z_out,   8'h00);
        chk("rst_cout",    bus.cout_out, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        push(8'hA5, 1'b1);
        chk("single_pushout", bus.pushout, 1'b1);
        chk("single_z",       bus.z_out,   8'hA5);
        chk("single_cout",    bus.cout_out, 1'b1);
        chk("single_cnt1",    bus.count,   1);
        @(negedge clk);
        chk("single_cnt0",    bus.count,   0);
        chk_log("single_log", '{8'hA5});

        // Fill to full, fifth value held upstream
        bus.stopin = 1'b1;
        for (int v = 1; v <= 4; v++) push(8'(v), 1'b0);
        chk("full_count",   bus.count,   4);
        chk("full_stopout", bus.stopout, 1'b1);
        bus.pushin = 1'b1;
        bus.z_in   = 8'h05;
        repeat (2) @(negedge clk);
        chk("full_hold_count", bus.count, 4);
        chk("full_hold_head",  bus.z_out, 8'h01);
        bus.stopin = 1'b0;
        push(8'h05, 1'b0);
        wait_empty();
        chk_log("fill_log", '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05});

        // Simultaneous push/pop at count=2
        bus.stopin = 1'b1;
        push(8'h0A, 1'b0);
        push(8'h0B, 1'b1);
        chk("simul_pre_count", bus.count, 2);
        bus.stopin = 1'b0;
        push(8'h10, 1'b0);
        chk("simul_count", bus.count, 2);
        chk("simul_head",  bus.z_out, 8'h0B);
        wait_empty();
        chk_log("simul_log", '{8'h0A, 8'h0B, 8'h10});

        // Wrap-around with stopin toggling
        fork
            for (int v = 0; v < 10; v++) push(8'(v), v[0]);
            for (int i = 0; i < 40; i++) begin
                bus.stopin = (i % 2 == 0);
                @(negedge clk);
            end
        join
        bus.stopin = 1'b0;
        wait_empty();
        chk_log("wrap_log", '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
                              8'h05, 8'h06, 8'h07, 8'h08, 8'h09});

        // Asynchronous reset with three entries held
        bus.stopin = 1'b1;
        push(8'h31, 1'b1);
        push(8'h32, 1'b0);
        push(8'h33, 1'b1);
        chk("mid_pre_count", bus.count, 3);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_pushout", bus.pushout, 1'b0);
        chk("mid_rst_count",   bus.count,   0);
        chk("mid_rst_z",       bus.z_out,   8'h00);
        chk("mid_rst_stopout", bus.stopout, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        out_log.delete();
        bus.stopin = 1'b0;
        @(negedge clk);
        push(8'hFF, 1'b0);
        chk("post_rst_z",     bus.z_out, 8'hFF);
        chk("post_rst_count", bus.count, 1);
        wait_empty();
        chk_log("post_rst_log", '{8'hFF});

`ifdef ALU_RESULT_FIFO_PARITY_EN
        // Parity of stored entries
        bus.stopin = 1'b1;
        push(8'h07, 1'b0);
        chk("par_07", bus.par_out, 1'b1);
        bus.stopin = 1'b0;
        push(8'h03, 1'b0);
        chk("par_03", bus.par_out, 1'b0);
        wait_empty();
        chk("par_empty", bus.par_out, 1'b0);
        out_log.delete();
`endif

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
